// File: rtl/line_raster_stream.sv
// line_raster_stream: Bresenham line walker for all eight octants.
// Emits one pixel per accepted handshake on a valid/ready stream and
// holds no picture memory. Supports abort, pixel count and backpressure.
module line_raster_stream #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               abort,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic [COORD_W:0]   pix_count,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched endpoints
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    // Current pixel
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    // Absolute deltas and step directions (1 = step towards smaller values)
    logic [COORD_W:0]   dx_q, dx_d, dy_q, dy_d;
    logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    // Bresenham error term; wide enough that 2*err never overflows
    logic signed [COORD_W+2:0] err_q, err_d;
    logic [COORD_W:0]   count_q, count_d;

    // Signed views of the deltas used in the error arithmetic
    logic signed [COORD_W+2:0] dx_s, dy_s, neg_dy_s, e2;
    logic                      at_end;
    logic                      handshake;

    assign dx_s      = signed'({2'b00, dx_q});
    assign dy_s      = signed'({2'b00, dy_q});
    assign neg_dy_s  = -dy_s;
    assign e2        = err_q <<< 1;
    assign at_end    = (cx_q == x1_q) && (cy_q == y1_q);
    assign handshake = (state_q == S_EMIT) && pix_ready;

    assign busy      = (state_q != S_IDLE);
    assign pix_valid = (state_q == S_EMIT);
    assign pix_x     = cx_q;
    assign pix_y     = cy_q;
    assign pix_last  = pix_valid && at_end;
    assign pix_count = count_q;
    assign done      = (state_q == S_DONE);

    // Next-state logic: setup of line parameters, stepping and abort handling
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        count_d  = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    count_d = '0;
                end
            end

            S_SETUP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sx_neg_d = (x1_q < x0_q);
                    sy_neg_d = (y1_q < y0_q);
                    dx_d     = (x1_q >= x0_q) ? ({1'b0, x1_q} - {1'b0, x0_q})
                                              : ({1'b0, x0_q} - {1'b0, x1_q});
                    dy_d     = (y1_q >= y0_q) ? ({1'b0, y1_q} - {1'b0, y0_q})
                                              : ({1'b0, y0_q} - {1'b0, y1_q});
                    err_d    = signed'({2'b00, dx_d}) - signed'({2'b00, dy_d});
                    cx_d     = x0_q;
                    cy_d     = y0_q;
                    state_d  = S_EMIT;
                end
            end

            S_EMIT: begin
                // An accepted pixel counts even when abort arrives with it
                if (handshake) begin
                    count_d = count_q + 1'b1;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (handshake) begin
                    if (at_end) begin
                        state_d = S_DONE;
                    end else begin
                        // Both axis updates may apply in one step (diagonal)
                        if (e2 >= neg_dy_s) begin
                            err_d = err_d - dy_s;
                            cx_d  = sx_neg_q ? (cx_q - 1'b1) : (cx_q + 1'b1);
                        end
                        if (e2 <= dx_s) begin
                            err_d = err_d + dx_s;
                            cy_d  = sy_neg_q ? (cy_q - 1'b1) : (cy_q + 1'b1);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/line_raster_stream.md
# line_raster_stream

Parametrised successor to the fixed 64×64 line rasteriser in the 2D GPU raster path. Takes two endpoints of configurable coordinate width and walks the Bresenham line for all eight octants. Emits one pixel per cycle on a valid/ready stream, so a downstream frame-buffer writer owns pixel storage and this block holds no picture memory. Adds abort, pixel count and backpressure, which the previous generation lacked.

## Interface
- COORD_W, 8, coordinate width in bits (unsigned); legal 4..12
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a line; sampled only in IDLE
- x0, y0  in  COORD_W  start point, sampled with start
- x1, y1  in  COORD_W  end point, sampled with start
- abort  in  1  terminate current line
- busy  out  1  high in any state other than IDLE
- pix_valid  out  1  pix_x/pix_y hold a pixel
- pix_ready  in  1  consumer accepts the pixel
- pix_x, pix_y  out  COORD_W  pixel coordinate
- pix_last  out  1  qualifies the final pixel of the line (valid only with pix_valid)
- pix_count  out  COORD_W+1  pixels accepted in the current/last line
- done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- Reset value of every output and register is 0; state is IDLE.
- States: IDLE, SETUP, EMIT, DONE.
- IDLE → SETUP when start=1.
  - Latch endpoints.
  - Clear pix_count.
- SETUP computes the line parameters:
  - dx = |x1−x0| and dy = |y1−y0|, each COORD_W+1 bits unsigned.
  - sx = +1 if x1≥x0 else −1; sy = +1 if y1≥y0 else −1.
  - err = dx − dy, signed COORD_W+3.
  - (cx, cy) = (x0, y0).
  - Always → EMIT.
- EMIT:
  - pix_valid=1 with pix_x=cx, pix_y=cy.
  - pix_last=1 when cx==x1 and cy==y1.
  - On handshake (pix_valid & pix_ready), pix_count increments.
  - If pix_last: → DONE.
  - Otherwise take one step, where e2 = 2·err (signed COORD_W+3):
    - If e2 ≥ −dy: err −= dy and cx += sx.
    - If e2 ≤ dx: err += dx and cy += sy.
    - Both updates may apply in the same step (diagonal); the err changes sum.
  - Without a handshake, all state holds.
- DONE: done=1 for one cycle, then → IDLE.
- abort=1 in SETUP or EMIT forces → IDLE next edge.
  - done is not pulsed.
  - pix_count keeps the number of pixels accepted so far.
  - If the handshake and abort occur in the same cycle, the pixel counts as accepted, then the block goes IDLE.
  - abort is ignored in IDLE and DONE.
- start while busy is ignored; endpoint inputs are don't-care outside the IDLE start cycle.
- Total pixels for a line = max(dx, dy) + 1. cx/cy never leave [0, 2^COORD_W−1].

## Timing
- start sampled at edge 0: SETUP in cycle 1, first pix_valid in cycle 2.
- With pix_ready held high, one pixel per cycle.
  - Last pixel in cycle N+1.
  - done in cycle N+2.
  - busy falls at cycle N+3.
- A new start is accepted in the cycle busy=0, so the back-to-back line period is N+3 cycles.
- While pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_last are stable.
- pix_valid never drops without a handshake, except on abort or rst.
- rst mid-line immediately clears all outputs, including pix_valid, asynchronously.

## Test plan
- Horizontal line, COORD_W=8, (0,5)→(7,5), ready=1:
  - Pixels x=0..7 at y=5 in cycles 2..9.
  - pix_last in cycle 9; done in cycle 10; pix_count=8.
- Steep negative line (3,10)→(1,2):
  - 9 pixels, cy strictly decreasing 10..2, cx non-increasing from 3 to 1.
  - Last pixel is (1,2); pix_count=9.
- Single point (4,4)→(4,4):
  - One pixel (4,4) with pix_last=1 in cycle 2.
  - done in cycle 3; pix_count=1.
- Backpressure on diagonal (0,0)→(5,5) with pix_ready toggling pseudo-randomly:
  - Exactly 6 pixels (k,k), each stable while stalled.
  - No duplicates; done once.
- Abort after 3 accepted pixels of (0,0)→(20,0):
  - pix_valid low the next cycle; no done; pix_count=3; busy=0.
  - A new start then restarts cleanly.
- Extreme line (255,0)→(0,255), COORD_W=8:
  - 256 pixels (255−k, k) with no wrap or overflow; pix_count=256.
- Additional check: rst asserted mid-line clears all outputs immediately.
